// File: rtl/trig_gen.sv
// rtl/trig_gen.sv - retriggerable fixed-width pulse generator with one-deep pending request and sticky overrun
module trig_gen #(
    parameter int WIDTH = 10050,
    parameter int GAP   = 10050
) (
    input  logic C,
    input  logic RN,
    input  logic EN,
    input  logic REQ,
    input  logic CLR,
    output logic O,
    output logic BUSY,
    output logic OVF
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Counters hold "cycles remaining minus one", so the load values are N-1.
    localparam logic [15:0] LP_W_LOAD = 16'(WIDTH - 1);
    localparam logic [15:0] LP_G_LOAD = 16'(GAP - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        r_pend;
    logic        w_pend_nxt;
    logic        r_o;
    logic        w_o_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_ovf;
    logic        w_ovf_nxt;
    logic        w_ovr;

    // State, counter, pending latch and registered outputs.
    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
            r_cnt   <= 16'd0;
            r_pend  <= 1'b0;
            r_o     <= 1'b0;
            r_busy  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_o     <= w_o_nxt;
            r_busy  <= w_busy_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    // Next-state, counter and pending/overrun decisions; outputs follow the next state.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pend_nxt  = r_pend;
        w_ovr       = 1'b0;

        if (!EN) begin
            // Abort: any pulse in flight and any queued request are discarded.
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = 16'd0;
            w_pend_nxt  = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // A request left pending at a GAP exit starts the pulse from IDLE;
                    // a simultaneous fresh request then becomes the new pending one.
                    if (REQ || r_pend) begin
                        w_state_nxt = S_HIGH;
                        w_cnt_nxt   = LP_W_LOAD;
                        w_pend_nxt  = r_pend && REQ;
                    end
                end
                S_HIGH: begin
                    if (r_cnt == 16'd0) begin
                        w_state_nxt = S_GAP;
                        w_cnt_nxt   = LP_G_LOAD;
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                    end
                    if (REQ) begin
                        if (r_pend) w_ovr = 1'b1;
                        else        w_pend_nxt = 1'b1;
                    end
                end
                S_GAP: begin
                    if (r_cnt == 16'd0) begin
                        if (r_pend) begin
                            // Pending pulse consumes the latch on this edge, so a
                            // request arriving now has nowhere to go.
                            w_state_nxt = S_HIGH;
                            w_cnt_nxt   = LP_W_LOAD;
                            w_pend_nxt  = 1'b0;
                            w_ovr       = REQ;
                        end else begin
                            w_state_nxt = S_IDLE;
                            w_cnt_nxt   = 16'd0;
                            w_pend_nxt  = REQ;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - 16'd1;
                        if (REQ) begin
                            if (r_pend) w_ovr = 1'b1;
                            else        w_pend_nxt = 1'b1;
                        end
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = 16'd0;
                    w_pend_nxt  = 1'b0;
                end
            endcase
        end

        w_o_nxt    = (w_state_nxt == S_HIGH);
        w_busy_nxt = (w_state_nxt != S_IDLE);
        // A new overrun beats a clear on the same edge.
        w_ovf_nxt  = w_ovr ? 1'b1 : (CLR ? 1'b0 : r_ovf);
    end

    assign O    = r_o;
    assign BUSY = r_busy;
    assign OVF  = r_ovf;

endmodule

// File: tb/tb_trig_gen.sv
// tb/tb_trig_gen.sv - self-checking bench for trig_gen
module tb_trig_gen;

    logic C = 1'b0;
    logic RN, EN, REQ, CLR;
    logic o4, b4, v4, o1, b1, v1;

    int n_pass = 0;
    int n_total = 0;
    int n_edge = 0;

    trig_gen #(.WIDTH(4), .GAP(3)) u4 (
        .C(C), .RN(RN), .EN(EN), .REQ(REQ), .CLR(CLR),
        .O(o4), .BUSY(b4), .OVF(v4)
    );

    trig_gen #(.WIDTH(1), .GAP(1)) u1 (
        .C(C), .RN(RN), .EN(EN), .REQ(REQ), .CLR(CLR),
        .O(o1), .BUSY(b1), .OVF(v1)
    );

    always #5 C = ~C;

    initial begin
        #1000000;
        $display("FAIL timeout passed=%0d total=%0d", n_pass, n_total);
        $fatal(1, "timeout");
    end

    // Reference model: a pulse is a start time; output is high for the first
    // w cycles after it and the generator is busy for w+g cycles.
    typedef struct {
        bit act;
        int t0;
        bit pend;
        bit ovf;
    } mst_t;

    mst_t m[2];
    int   wv[2] = '{4, 1};
    int   gv[2] = '{3, 1};

    function automatic mst_t mstep(mst_t s, int w, int g, int n, bit en, bit req, bit clr);
        bit ov;
        bit fin;
        ov = 1'b0;
        if (!en) begin
            s.act  = 1'b0;
            s.pend = 1'b0;
        end else begin
            fin = s.act && (n == s.t0 + w + g);
            if (s.act && !fin) begin
                if (req) begin
                    if (s.pend) ov = 1'b1;
                    else        s.pend = 1'b1;
                end
            end else if (fin) begin
                if (s.pend) begin
                    s.t0   = n;
                    s.pend = 1'b0;
                    ov     = req;
                end else begin
                    s.act  = 1'b0;
                    s.pend = req;
                end
            end else if (req || s.pend) begin
                s.act  = 1'b1;
                s.t0   = n;
                s.pend = s.pend && req;
            end
        end
        if (ov)       s.ovf = 1'b1;
        else if (clr) s.ovf = 1'b0;
        return s;
    endfunction

    function automatic bit m_o(int k);
        return m[k].act && ((n_edge - m[k].t0) < wv[k]);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m[k].act  = 1'b0;
            m[k].t0   = 0;
            m[k].pend = 1'b0;
            m[k].ovf  = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%b required=%b at t=%0t", name, act, exp, $time);
    endtask

    // One clock: drive at negedge, step the model at posedge, return at the next negedge.
    task automatic cyc(input bit en, input bit req, input bit clr);
        EN  = en;
        REQ = req;
        CLR = clr;
        @(posedge C);
        n_edge++;
        for (int k = 0; k < 2; k++) m[k] = mstep(m[k], wv[k], gv[k], n_edge, en, req, clr);
        @(negedge C);
    endtask

    task automatic do_reset();
        RN  = 1'b0;
        EN  = 1'b0;
        REQ = 1'b0;
        CLR = 1'b0;
        repeat (2) @(negedge C);
        RN = 1'b1;
        model_reset();
    endtask

    function automatic bit sb(string s, int i);
        return s[i] == 8'h31;
    endfunction

    typedef struct {
        bit en;
        bit req;
        bit clr;
        bit o;
        bit busy;
        bit ovf;
    } vec_t;

    vec_t vq[$];

    initial begin
        string s_req, s_clr, s_o, s_b, s_v;
        vec_t  vr;

        RN = 1'b0; EN = 1'b0; REQ = 1'b0; CLR = 1'b0;
        model_reset();
        @(negedge C);
        do_reset();

        chk("rst_o4", o4, 1'b0);
        chk("rst_b4", b4, 1'b0);
        chk("rst_v4", v4, 1'b0);
        chk("rst_o1", o1, 1'b0);
        chk("rst_b1", b1, 1'b0);
        chk("rst_v1", v1, 1'b0);

        // Single pulse; two-request back-to-back; three requests with overrun and clear.
        s_req = {"100000000", "101000000000000", "101001000000000"};
        s_clr = {"000000000", "000000000000000", "000000000000100"};
        s_o   = {"111100000", "111100011110000", "111100011110000"};
        s_b   = {"111111100", "111111111111110", "111111111111110"};
        s_v   = {"000000000", "000000000000000", "000001111111000"};
        for (int i = 0; i < s_req.len(); i++) begin
            vr.en   = 1'b1;
            vr.req  = sb(s_req, i);
            vr.clr  = sb(s_clr, i);
            vr.o    = sb(s_o, i);
            vr.busy = sb(s_b, i);
            vr.ovf  = sb(s_v, i);
            vq.push_back(vr);
        end
        for (int i = 0; i < vq.size(); i++) begin
            cyc(vq[i].en, vq[i].req, vq[i].clr);
            chk($sformatf("vec%0d_o", i), o4, vq[i].o);
            chk($sformatf("vec%0d_busy", i), b4, vq[i].busy);
            chk($sformatf("vec%0d_ovf", i), v4, vq[i].ovf);
        end

        // Abort by EN=0 keeps OVF, drops pulse and pending; no resume afterwards.
        cyc(1, 1, 0); cyc(1, 0, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        chk("abort_pre_ovf", v4, 1'b1);
        cyc(0, 0, 0);
        chk("abort_o", o4, 1'b0);
        chk("abort_busy", b4, 1'b0);
        chk("abort_ovf_kept", v4, 1'b1);
        repeat (2) begin
            cyc(0, 1, 0);
            chk("en0_req_ignored", b4, 1'b0);
        end
        repeat (8) begin
            cyc(1, 0, 0);
            chk("no_resume_o", o4, 1'b0);
            chk("no_resume_busy", b4, 1'b0);
        end
        cyc(1, 0, 1);
        chk("clr_ovf", v4, 1'b0);

        // Overrun and clear on the same edge: set wins.
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 1);
        chk("set_beats_clr", v4, 1'b1);
        repeat (16) cyc(1, 0, 1);
        chk("drain_busy", b4, 1'b0);
        chk("drain_ovf", v4, 1'b0);

        // Asynchronous reset mid-HIGH, then a normal pulse.
        cyc(1, 1, 0); cyc(1, 1, 0); cyc(1, 1, 0);
        chk("pre_rst_o", o4, 1'b1);
        chk("pre_rst_ovf", v4, 1'b1);
        #2 RN = 1'b0;
        #1;
        chk("arst_o", o4, 1'b0);
        chk("arst_busy", b4, 1'b0);
        chk("arst_ovf", v4, 1'b0);
        @(negedge C);
        RN = 1'b1;
        model_reset();
        cyc(1, 1, 0);
        chk("post_rst_o_e0", o4, 1'b1);
        for (int i = 1; i < 5; i++) begin
            cyc(1, 0, 0);
            chk($sformatf("post_rst_o_e%0d", i), o4, (i < 4) ? 1'b1 : 1'b0);
        end

        // WIDTH=1, GAP=1 with REQ held for 10 cycles.
        do_reset();
        s_req = "1111111111000";
        s_o   = "1010101010100";
        s_b   = "1111111111110";
        s_v   = "0011111111111";
        for (int i = 0; i < s_req.len(); i++) begin
            cyc(1, sb(s_req, i), 0);
            chk($sformatf("w1_e%0d_o", i), o1, sb(s_o, i));
            chk($sformatf("w1_e%0d_busy", i), b1, sb(s_b, i));
            chk($sformatf("w1_e%0d_ovf", i), v1, sb(s_v, i));
        end

        // Randomized run against the model for both configurations.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 15) != 0), ($urandom_range(0, 9) < 3), ($urandom_range(0, 19) == 0));
            chk("rnd_o4", o4, m_o(0));
            chk("rnd_b4", b4, m[0].act);
            chk("rnd_v4", v4, m[0].ovf);
            chk("rnd_o1", o1, m_o(1));
            chk("rnd_b1", b1, m[1].act);
            chk("rnd_v1", v1, m[1].ovf);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/trig_gen.md
TRIG_GEN -- requirements
Module: trig_gen

Interface
REQ-001 Parameter WIDTH, default 10050, SHALL set the output pulse high time in C cycles; the default is chosen above the 10000-cycle trigger input filter threshold.
REQ-002 Parameter GAP, default 10050, SHALL set the minimum output low time in C cycles between pulses.
REQ-003 C  input  1  SHALL be the single clock; all state changes on posedge C.
REQ-004 RN  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 EN  input  1  SHALL be the generator enable: 1 = run, 0 = abort and idle.
REQ-006 REQ  input  1  SHALL be the trigger request, sampled each cycle; each high cycle counts as one request.
REQ-007 CLR  input  1  SHALL be the synchronous clear of the OVF flag.
REQ-008 O  output  1  SHALL be the trigger output, registered.
REQ-009 BUSY  output  1  SHALL be high whenever the state is not IDLE, registered.
REQ-010 OVF  output  1  SHALL be the sticky overrun flag, registered.

Function
REQ-011 The block SHALL implement the states IDLE, HIGH and GAP, a 16-bit down-counter CNT, and a one-deep pending latch PEND.
REQ-012 WIDTH and GAP SHALL each be in the range 1..65535; a value of 0 SHALL be a configuration error that is not supported.
REQ-013 IDLE with EN=1 and REQ=1 at edge k SHALL enter HIGH with CNT=WIDTH-1; O SHALL be 1 from edge k, so O goes high in the cycle after REQ is sampled.
REQ-014 In HIGH, O SHALL stay 1 for exactly WIDTH cycles; at CNT=0 the block SHALL enter GAP with CNT=GAP-1 and O=0.
REQ-015 In GAP, O SHALL stay 0 for exactly GAP cycles; at CNT=0 it SHALL enter HIGH if PEND=1 (clearing PEND and loading CNT=WIDTH-1), or IDLE otherwise.
REQ-016 Back-to-back pulses SHALL give a period of exactly WIDTH+GAP cycles, with no idle cycle inserted.
REQ-017 REQ=1 in HIGH or GAP with PEND=0 SHALL set PEND.
REQ-018 REQ=1 in HIGH or GAP with PEND=1 SHALL set OVF and drop the request.
REQ-019 REQ=1 on the same edge that GAP exits with PEND=1 SHALL count as an overrun.
REQ-020 REQ=1 on the same edge that GAP exits with PEND=0 SHALL set PEND, and the block SHALL still go to IDLE first.
REQ-021 CLR=1 SHALL clear OVF; if an overrun occurs on the same edge, setting OVF SHALL win.
REQ-022 EN=0 SHALL, at the next edge, force IDLE with O=0, PEND=0 and CNT=0; OVF SHALL be retained.
REQ-023 REQ SHALL be ignored while EN=0.
REQ-024 A pulse aborted by EN=0 SHALL NOT be resumed when EN returns to 1.
REQ-025 BUSY SHALL be 1 in HIGH and GAP and 0 in IDLE, and SHALL update on the same edge as the state.
REQ-026 In IDLE with EN=1 and REQ held high, a new pulse SHALL start on every GAP exit; the pending path SHALL apply in that case.

Reset
REQ-027 RN=0 SHALL immediately force O=0, BUSY=0, OVF=0, PEND=0, CNT=0 and state IDLE, regardless of C.
REQ-028 Release of RN SHALL take effect on the first posedge C at which RN=1; RN asserted mid-pulse SHALL drop O in the same cycle.

Verification
REQ-029 WIDTH=4, GAP=3, EN=1, a single 1-cycle REQ at edge 0 -> O high for edges 0..3, low from edge 4; BUSY low again at edge 7; OVF=0.
REQ-030 WIDTH=4, GAP=3, REQ pulses at edge 0 and edge 2 -> second pulse O high for edges 7..10; period 7; OVF=0.
REQ-031 WIDTH=4, GAP=3, REQ at edges 0, 2 and 5 -> two pulses only; OVF=1 from edge 5; CLR at edge 12 -> OVF=0 at edge 12.
REQ-032 WIDTH=4, GAP=3, REQ at edge 0, then EN=0 at edge 2 -> O=0 and BUSY=0 from edge 2; EN=1 later with no REQ -> O stays 0.
REQ-033 WIDTH=4, GAP=3, RN pulsed low mid-HIGH -> O, BUSY and OVF go to 0 asynchronously; the next REQ after release gives a normal 4-cycle pulse.
REQ-034 WIDTH=1, GAP=1, REQ held high for 10 cycles -> alternating 1-cycle high and 1-cycle low pulses with period 2 for the duration of REQ plus the pending pulse, then OVF=1.
